// File: rtl/tl_mon_pkg.sv
// Shared types and constants for the traffic-light lamp monitor.
// STUCK_MAX is only consumed when TL_STUCK_WDOG_EN is defined.
package tl_mon_pkg;

  typedef enum logic [1:0] {
    UNK = 2'd0,
    GRN = 2'd1,
    YEL = 2'd2,
    RED = 2'd3
  } lamp_st_e;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FAULT = 2'd1,
    ARM   = 2'd2
  } top_st_e;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_CONFLICT = 3'd1;
  localparam logic [2:0] FC_ENC      = 3'd2;
  localparam logic [2:0] FC_TRANS    = 3'd3;
  localparam logic [2:0] FC_SHORT    = 3'd4;
  localparam logic [2:0] FC_STUCK    = 3'd5;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam logic [7:0] MIN_YEL   = 8'd2;
  localparam logic [7:0] STUCK_MAX = 8'd200;
  localparam logic [7:0] FLASH_DIV = 8'd4;

  // Anything that is not exactly one lamp decodes to UNK.
  function automatic lamp_st_e lamp_decode(input logic [2:0] lamp);
    case (lamp)
      LAMP_G:  lamp_decode = GRN;
      LAMP_Y:  lamp_decode = YEL;
      LAMP_R:  lamp_decode = RED;
      default: lamp_decode = UNK;
    endcase
  endfunction

endpackage

// File: rtl/tl_lamp_monitor_if.sv
// Lamp monitor bus: sequencer lamps and operator ack in, lamp drive and fault status out.
interface tl_lamp_monitor_if;
  logic [2:0] lamp_a;
  logic [2:0] lamp_b;
  logic       ack;
  logic [2:0] drv_a;
  logic [2:0] drv_b;
  logic       fault;
  logic [2:0] fault_code;

  modport master (
    output lamp_a, lamp_b, ack,
    input  drv_a, drv_b, fault, fault_code
  );

  modport slave (
    input  lamp_a, lamp_b, ack,
    output drv_a, drv_b, fault, fault_code
  );
endinterface

// File: rtl/tl_lamp_tracker.sv
// Per-approach lamp decode, sequence tracker, yellow-length and stuck checks.
// The stuck watchdog is built only when TL_STUCK_WDOG_EN is defined.
module tl_lamp_tracker
  import tl_mon_pkg::*;
(
  input  logic       clock,
  input  logic       pg0,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [2:0] lamp_i,
  output logic       go_o,
  output logic       err_enc_o,
  output logic       err_trans_o,
  output logic       err_short_o,
  output logic       err_stuck_o
);

  lamp_st_e   st_q, st_d, dec_s;
  logic [7:0] ycnt_q, ycnt_d;

  always_comb begin
    dec_s       = lamp_decode(lamp_i);
    go_o        = en_i && ((dec_s == GRN) || (dec_s == YEL));
    err_enc_o   = en_i && (dec_s == UNK);
    err_trans_o = en_i && (((st_q == GRN) && (dec_s == RED)) ||
                           ((st_q == YEL) && (dec_s == GRN)) ||
                           ((st_q == RED) && (dec_s == YEL)));
    err_short_o = en_i && (st_q == YEL) && (dec_s == RED) && (ycnt_q < MIN_YEL);
    st_d   = st_q;
    ycnt_d = ycnt_q;
    if (clr_i) begin
      st_d   = UNK;
      ycnt_d = 8'd0;
    end else if (en_i) begin
      // A bad encoding lands in UNK so the next legal sample restarts checking.
      st_d = dec_s;
      if (dec_s != YEL) begin
        ycnt_d = 8'd0;
      end else if (st_q != YEL) begin
        ycnt_d = 8'd1;
      end else if (ycnt_q < MIN_YEL) begin
        ycnt_d = ycnt_q + 8'd1;
      end else begin
        ycnt_d = ycnt_q;
      end
    end else begin
      st_d   = st_q;
      ycnt_d = ycnt_q;
    end
  end

  always_ff @(posedge clock) begin
    if (pg0) begin
      st_q   <= UNK;
      ycnt_q <= 8'd0;
    end else begin
      st_q   <= st_d;
      ycnt_q <= ycnt_d;
    end
  end

`ifdef TL_STUCK_WDOG_EN
  logic [7:0] stk_q, stk_d;

  always_comb begin
    stk_d = stk_q;
    if (clr_i) begin
      stk_d = 8'd0;
    end else if (!en_i) begin
      stk_d = stk_q;
    end else if (st_d != st_q) begin
      stk_d = 8'd0;
    end else if (stk_q != 8'hFF) begin
      stk_d = stk_q + 8'd1;
    end else begin
      stk_d = stk_q;
    end
  end

  assign err_stuck_o = en_i && !clr_i && (stk_d >= STUCK_MAX);

  always_ff @(posedge clock) begin
    if (pg0) begin
      stk_q <= 8'd0;
    end else begin
      stk_q <= stk_d;
    end
  end
`else
  assign err_stuck_o = 1'b0;
`endif

endmodule

// File: rtl/tl_lamp_monitor.sv
// Lamp monitor top: input register stage, conflict/priority checks and the RUN/FAULT/ARM FSM.
// Stuck-lamp faults (code 5) exist only when TL_STUCK_WDOG_EN is defined.
module tl_lamp_monitor
  import tl_mon_pkg::*;
(
  input logic              clock,
  input logic              pg0,
  tl_lamp_monitor_if.slave bus
);

  logic [2:0] s1_a_q, s1_b_q;
  logic       s1_vld_q;
  top_st_e    st_q;
  logic [2:0] drv_a_q, drv_b_q, code_q;
  logic       fault_q, flash_q;
  logic [7:0] fcnt_q;

  logic       clr_s, go_a_s, go_b_s;
  logic       enc_a_s, enc_b_s, trans_a_s, trans_b_s;
  logic       short_a_s, short_b_s, stuck_a_s, stuck_b_s;
  logic       conflict_s, enc_s, flash_nxt_s;
  logic [2:0] det_code_s;
  logic [7:0] fcnt_nxt_s;

  // Stage 1; valid stays low for the first sample after reset so a stale value is never checked.
  always_ff @(posedge clock) begin
    if (pg0) begin
      s1_a_q   <= LAMP_R;
      s1_b_q   <= LAMP_R;
      s1_vld_q <= 1'b0;
    end else begin
      s1_a_q   <= bus.lamp_a;
      s1_b_q   <= bus.lamp_b;
      s1_vld_q <= 1'b1;
    end
  end

  assign clr_s = (st_q != RUN);

  tl_lamp_tracker u_trk_a (
    .clock(clock), .pg0(pg0), .clr_i(clr_s), .en_i(s1_vld_q), .lamp_i(s1_a_q),
    .go_o(go_a_s), .err_enc_o(enc_a_s), .err_trans_o(trans_a_s),
    .err_short_o(short_a_s), .err_stuck_o(stuck_a_s)
  );

  tl_lamp_tracker u_trk_b (
    .clock(clock), .pg0(pg0), .clr_i(clr_s), .en_i(s1_vld_q), .lamp_i(s1_b_q),
    .go_o(go_b_s), .err_enc_o(enc_b_s), .err_trans_o(trans_b_s),
    .err_short_o(short_b_s), .err_stuck_o(stuck_b_s)
  );

  always_comb begin
    conflict_s = go_a_s && go_b_s;
    enc_s      = enc_a_s || enc_b_s;
    if (conflict_s) begin
      det_code_s = FC_CONFLICT;
    end else if (enc_s) begin
      det_code_s = FC_ENC;
    end else if (trans_a_s || trans_b_s) begin
      det_code_s = FC_TRANS;
    end else if (short_a_s || short_b_s) begin
      det_code_s = FC_SHORT;
    end else if (stuck_a_s || stuck_b_s) begin
      det_code_s = FC_STUCK;
    end else begin
      det_code_s = FC_NONE;
    end
    if (fcnt_q == (FLASH_DIV - 8'd1)) begin
      fcnt_nxt_s  = 8'd0;
      flash_nxt_s = ~flash_q;
    end else begin
      fcnt_nxt_s  = fcnt_q + 8'd1;
      flash_nxt_s = flash_q;
    end
  end

  // Top FSM; every output is registered here.
  always_ff @(posedge clock) begin
    if (pg0) begin
      st_q    <= RUN;
      drv_a_q <= LAMP_R;
      drv_b_q <= LAMP_R;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
      flash_q <= 1'b1;
      fcnt_q  <= 8'd0;
    end else begin
      case (st_q)
        RUN: begin
          if (!s1_vld_q) begin
            drv_a_q <= LAMP_R;
            drv_b_q <= LAMP_R;
          end else if (det_code_s != FC_NONE) begin
            st_q    <= FAULT;
            fault_q <= 1'b1;
            code_q  <= det_code_s;
            drv_a_q <= LAMP_R;
            drv_b_q <= LAMP_R;
            flash_q <= 1'b1;
            fcnt_q  <= 8'd0;
          end else begin
            drv_a_q <= s1_a_q;
            drv_b_q <= s1_b_q;
          end
        end
        FAULT: begin
          if (bus.ack && !conflict_s && !enc_s) begin
            st_q    <= ARM;
            drv_a_q <= LAMP_R;
            drv_b_q <= LAMP_R;
          end else begin
            flash_q <= flash_nxt_s;
            fcnt_q  <= fcnt_nxt_s;
            drv_a_q <= {flash_nxt_s, 2'b00};
            drv_b_q <= {flash_nxt_s, 2'b00};
          end
        end
        ARM: begin
          // The sample seen during ARM is discarded; lamps stay solid red one more cycle.
          st_q    <= RUN;
          fault_q <= 1'b0;
          code_q  <= FC_NONE;
          drv_a_q <= LAMP_R;
          drv_b_q <= LAMP_R;
        end
        default: begin
          st_q    <= RUN;
          fault_q <= 1'b0;
          code_q  <= FC_NONE;
          drv_a_q <= LAMP_R;
          drv_b_q <= LAMP_R;
        end
      endcase
    end
  end

  assign bus.drv_a      = drv_a_q;
  assign bus.drv_b      = drv_b_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = code_q;

endmodule

// File: tb/tb_tl_lamp_monitor.sv
// Self-checking bench for tl_lamp_monitor: directed vector table, stuck-watchdog run,
// and randomized sequencer traffic checked against a rule-level reference model.
module tb_tl_lamp_monitor;
  import tl_mon_pkg::*;

  localparam int T_MIN_YEL = 2;
  localparam int T_STUCK   = 200;
  localparam int T_FLASH   = 4;
  localparam logic [2:0] R_ = 3'b100;
  localparam logic [2:0] Y_ = 3'b010;
  localparam logic [2:0] G_ = 3'b001;
  localparam logic [2:0] O_ = 3'b000;

  logic clock = 1'b0;
  logic pg0;
  tl_lamp_monitor_if bus ();

  tl_lamp_monitor dut (.clock(clock), .pg0(pg0), .bus(bus));

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       pg0;
    logic       ack;
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] xa;
    logic [2:0] xb;
    logic       xf;
    logic [2:0] xc;
  } vec_t;

  vec_t tbl[$];

  // reference model state: lamp index 0=G 1=Y 2=R, -1 unknown/bad
  int         m_prev[2];
  int         m_yrun[2];
  int         m_run[2];
  logic [2:0] m_s1[2];
  bit         m_vld;
  int         m_mode;
  int         m_ft;
  logic [2:0] e_da, e_db, e_code;
  logic       e_fault;

  function automatic vec_t mk(logic p, logic k, logic [2:0] a, logic [2:0] b,
                              logic [2:0] xa, logic [2:0] xb, logic xf, logic [2:0] xc);
    vec_t v;
    v.pg0 = p; v.ack = k; v.a = a; v.b = b;
    v.xa = xa; v.xb = xb; v.xf = xf; v.xc = xc;
    return v;
  endfunction

  function automatic int dec(logic [2:0] l);
    case (l)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -1;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_prev[i] = -1;
      m_yrun[i] = 0;
      m_run[i]  = 0;
    end
  endtask

  task automatic model_edge();
    int d[2];
    int code;
    int old_mode;
    bit conf, enc, trans, shrt, stk;
    if (pg0) begin
      e_da = R_; e_db = R_; e_fault = 1'b0; e_code = 3'd0;
      m_mode = 0; m_vld = 1'b0;
      model_clear();
    end else begin
      for (int i = 0; i < 2; i++) d[i] = dec(m_s1[i]);
      conf = (d[0] == 0 || d[0] == 1) && (d[1] == 0 || d[1] == 1);
      enc  = (d[0] < 0) || (d[1] < 0);
      trans = 1'b0; shrt = 1'b0; stk = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (m_prev[i] >= 0 && d[i] >= 0 && d[i] != m_prev[i] && d[i] != (m_prev[i] + 1) % 3)
          trans = 1'b1;
        if (m_prev[i] == 1 && d[i] == 2 && m_yrun[i] < T_MIN_YEL) shrt = 1'b1;
`ifdef TL_STUCK_WDOG_EN
        if (((d[i] == m_prev[i]) ? m_run[i] + 1 : 0) >= T_STUCK) stk = 1'b1;
`endif
      end
      code = conf ? 1 : enc ? 2 : trans ? 3 : shrt ? 4 : stk ? 5 : 0;
      old_mode = m_mode;
      case (old_mode)
        0: begin
          if (!m_vld) begin
            e_da = R_; e_db = R_;
          end else if (code != 0) begin
            e_fault = 1'b1; e_code = 3'(code); e_da = R_; e_db = R_;
            m_mode = 1; m_ft = 0;
          end else begin
            e_da = m_s1[0]; e_db = m_s1[1];
          end
        end
        1: begin
          m_ft++;
          if (bus.ack && !conf && !enc) begin
            m_mode = 2; e_da = R_; e_db = R_;
          end else begin
            e_da = ((m_ft / T_FLASH) % 2 == 0) ? R_ : O_;
            e_db = e_da;
          end
        end
        default: begin
          m_mode = 0; e_fault = 1'b0; e_code = 3'd0; e_da = R_; e_db = R_;
        end
      endcase
      if (old_mode != 0) begin
        model_clear();
      end else if (m_vld) begin
        for (int i = 0; i < 2; i++) begin
          m_run[i]  = (d[i] == m_prev[i]) ? m_run[i] + 1 : 0;
          m_yrun[i] = (d[i] == 1) ? ((m_prev[i] == 1) ? m_yrun[i] + 1 : 1) : 0;
          m_prev[i] = d[i];
        end
      end
      m_vld = 1'b1;
    end
    m_s1[0] = bus.lamp_a;
    m_s1[1] = bus.lamp_b;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] xa, input logic [2:0] xb,
                       input logic xf, input logic [2:0] xc);
    checks++;
    if ({bus.drv_a, bus.drv_b, bus.fault, bus.fault_code} !== {xa, xb, xf, xc}) begin
      errors++;
      $display("FAIL %s: got drv_a=%b drv_b=%b fault=%b code=%0d, expected drv_a=%b drv_b=%b fault=%b code=%0d",
               name, bus.drv_a, bus.drv_b, bus.fault, bus.fault_code, xa, xb, xf, xc);
    end
  endtask

  task automatic drive(input logic p, input logic k, input logic [2:0] a, input logic [2:0] b);
    pg0 = p; bus.ack = k; bus.lamp_a = a; bus.lamp_b = b;
  endtask

  int ph, dur;
  logic [2:0] ra, rb;

  initial begin
    drive(1'b1, 1'b0, R_, R_);
    model_clear();
    m_s1[0] = R_; m_s1[1] = R_; m_vld = 1'b0; m_mode = 0; m_ft = 0;
    e_da = R_; e_db = R_; e_fault = 1'b0; e_code = 3'd0;

    // legal cycle, conflict with flash timing, ack blocked by conflict, ARM, codes 2/3/4, priority
    tbl.push_back(mk(1,0,R_,R_, R_,R_,0,0));
    tbl.push_back(mk(0,0,G_,R_, R_,R_,0,0));
    tbl.push_back(mk(0,0,G_,R_, G_,R_,0,0));
    tbl.push_back(mk(0,0,G_,R_, G_,R_,0,0));
    tbl.push_back(mk(0,0,Y_,R_, G_,R_,0,0));
    tbl.push_back(mk(0,0,Y_,R_, Y_,R_,0,0));
    tbl.push_back(mk(0,0,R_,R_, Y_,R_,0,0));
    tbl.push_back(mk(0,0,R_,R_, R_,R_,0,0));
    tbl.push_back(mk(0,0,R_,R_, R_,R_,0,0));
    tbl.push_back(mk(0,0,G_,G_, R_,R_,0,0));
    tbl.push_back(mk(0,0,R_,R_, R_,R_,1,1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,R_,R_, R_,R_,1,1));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0,0,R_,R_, O_,O_,1,1));
    tbl.push_back(mk(0,0,R_,R_, R_,R_,1,1));
    tbl.push_back(mk(0,0,G_,G_, R_,R_,1,1));
    tbl.push_back(mk(0,1,G_,G_, R_,R_,1,1));
    tbl.push_back(mk(0,1,R_,R_, R_,R_,1,1));
    tbl.push_back(mk(0,1,R_,R_, R_,R_,1,1));
    tbl.push_back(mk(0,0,R_,R_, R_,R_,0,0));
    tbl.push_back(mk(0,0,R_,R_, R_,R_,0,0));
    tbl.push_back(mk(0,0,3'b011,R_, R_,R_,0,0));
    tbl.push_back(mk(0,0,R_,R_, R_,R_,1,2));
    tbl.push_back(mk(1,0,R_,R_, R_,R_,0,0));
    tbl.push_back(mk(0,0,G_,R_, R_,R_,0,0));
    tbl.push_back(mk(0,0,R_,R_, G_,R_,0,0));
    tbl.push_back(mk(0,0,R_,R_, R_,R_,1,3));
    tbl.push_back(mk(0,1,R_,R_, R_,R_,1,3));
    tbl.push_back(mk(0,0,R_,R_, R_,R_,0,0));
    tbl.push_back(mk(0,0,G_,R_, R_,R_,0,0));
    tbl.push_back(mk(0,0,Y_,R_, G_,R_,0,0));
    tbl.push_back(mk(0,0,R_,R_, Y_,R_,0,0));
    tbl.push_back(mk(0,0,R_,R_, R_,R_,1,4));
    tbl.push_back(mk(1,0,R_,R_, R_,R_,0,0));
    tbl.push_back(mk(0,0,R_,G_, R_,R_,0,0));
    tbl.push_back(mk(0,0,3'b110,R_, R_,G_,0,0));
    tbl.push_back(mk(0,0,R_,R_, R_,R_,1,2));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].pg0, tbl[i].ack, tbl[i].a, tbl[i].b);
      tick();
      check($sformatf("vec%0d", i), tbl[i].xa, tbl[i].xb, tbl[i].xf, tbl[i].xc);
    end

    // lamps held red: stuck fault with the watchdog, silence without it
    drive(1'b1, 1'b0, R_, R_);
    tick();
    check("hold_reset", e_da, e_db, e_fault, e_code);
    drive(1'b0, 1'b0, R_, R_);
`ifdef TL_STUCK_WDOG_EN
    for (int i = 0; i < 250; i++) begin
      tick();
      check($sformatf("hold%0d", i), e_da, e_db, e_fault, e_code);
    end
    checks++;
    if ({bus.fault, bus.fault_code} !== {1'b1, 3'd5}) begin
      errors++;
      $display("FAIL stuck_code: got fault=%b code=%0d, expected fault=1 code=5", bus.fault, bus.fault_code);
    end
`else
    for (int i = 0; i < 1000; i++) begin
      tick();
      check($sformatf("hold%0d", i), e_da, e_db, e_fault, e_code);
    end
    checks++;
    if (bus.fault !== 1'b0) begin
      errors++;
      $display("FAIL no_stuck: got fault=%b code=%0d, expected fault=0", bus.fault, bus.fault_code);
    end
`endif

    // randomized sequencer traffic with occasional corruption, ack and reset
    drive(1'b1, 1'b0, R_, R_);
    tick();
    check("rand_reset", e_da, e_db, e_fault, e_code);
    ph = 5; dur = 0;
    for (int i = 0; i < 3000; i++) begin
      if (dur == 0) begin
        ph  = (ph + 1) % 6;
        dur = (ph == 0 || ph == 3) ? $urandom_range(1, 6) :
              (ph == 1 || ph == 4) ? $urandom_range(1, 3) : $urandom_range(1, 2);
      end
      dur--;
      case (ph)
        0:       begin ra = G_; rb = R_; end
        1:       begin ra = Y_; rb = R_; end
        3:       begin ra = R_; rb = G_; end
        4:       begin ra = R_; rb = Y_; end
        default: begin ra = R_; rb = R_; end
      endcase
      if ($urandom_range(0, 24) == 0) ra = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 24) == 0) rb = 3'($urandom_range(0, 7));
      drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0), ra, rb);
      tick();
      check($sformatf("rand%0d", i), e_da, e_db, e_fault, e_code);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tl_lamp_monitor.md
Name: tl_lamp_monitor

Overview:
- Downstream stage of the traffic-light sequencer. Consumes its six lamp outputs, grouped as two approaches (A, B) of {red, yellow, green}.
- Checks the lamps for conflicts, illegal encodings, illegal sequences, short yellow and stuck lamps.
- Drives the physical lamp lines. On any fault, latches a fault code and forces both approaches to flashing red until acknowledged.
- Offending lamp patterns never reach the drive outputs.

Parameters:
- MIN_YEL, 2: minimum consecutive yellow samples before leaving yellow.
- STUCK_MAX, 200: maximum consecutive cycles in one lamp state before a stuck fault (8-bit counter, saturating).
- FLASH_DIV, 4: half-period of the red flash in cycles.

Ports:
- clock  in  1  rising-edge clock, single domain
- pg0  in  1  synchronous active-high reset (codebase clear line)
- lamp_a  in  3  approach A lamps {R,Y,G} from sequencer
- lamp_b  in  3  approach B lamps {R,Y,G} from sequencer
- ack  in  1  operator fault acknowledge, level-sampled
- drv_a  out  3  approach A lamp drive {R,Y,G}
- drv_b  out  3  approach B lamp drive {R,Y,G}
- fault  out  1  latched fault flag
- fault_code  out  3  0 none, 1 conflict, 2 bad encoding, 3 bad transition, 4 short yellow, 5 stuck

Behaviour:
- Reset (pg0=1 at an edge):
  - drv_a = drv_b = 3'b100 (solid red); fault = 0; fault_code = 0.
  - Trackers go to UNK, all counters go to 0, top FSM goes to RUN.
  - Reset takes priority over every other event, including reset mid-fault or mid-ARM.
- Pipeline:
  - Stage 1 registers lamp_a and lamp_b.
  - Stage 2 evaluates the checks on the stage-1 values and registers fault, fault_code, drv_a and drv_b.
  - Latency from lamp input to drv/fault is 2 cycles.
- Per-approach tracker states: UNK, GRN, YEL, RED.
  - Encoding must be exactly one-hot. 000 or multi-hot raises code 2.
  - From UNK, any legal encoding is accepted with no transition check.
  - Legal transitions: G->G, G->Y, Y->Y, Y->R, R->R, R->G.
  - Illegal transitions raise code 3: G->R, Y->G, R->Y.
- Yellow counter:
  - Counts consecutive YEL samples and saturates at MIN_YEL.
  - Leaving YEL (to R) with count < MIN_YEL raises code 4.
- Conflict: both approaches decoded non-red (G or Y) in the same sample raises code 1.
- Stuck counter:
  - Resets to 0 on any state change and increments otherwise.
  - Reaching STUCK_MAX raises code 5.
- Priority when several faults are detected in the same sample: 1 > 2 > 3 > 4 > 5. Priority is evaluated across both approaches.
- Top FSM states: RUN, FAULT, ARM.
  - RUN: drv = stage-1 lamps. Any detected fault causes:
    - fault = 1 and fault_code latched in that same stage-2 cycle;
    - drv goes to the flash pattern in that cycle;
    - transition to FAULT.
  - FAULT:
    - fault_code is held; later faults are ignored.
    - drv_a = drv_b = {flash,0,0}.
    - flash starts at 1, toggles every FLASH_DIV cycles, and has a period of 2*FLASH_DIV.
    - ack = 1 while the current sample shows no conflict and no bad encoding -> ARM. Otherwise ack is ignored.
  - ARM, one cycle:
    - Trackers go to UNK and counters clear.
    - drv = 3'b100 on both approaches.
    - fault and fault_code stay set.
    - Next cycle: RUN, with fault = 0 and fault_code = 0.
- Simultaneous ack and a new fault condition in FAULT: stay in FAULT.

Optional Feature:
- Macro TL_STUCK_WDOG_EN.
- When defined: the stuck counters exist and code 5 is generated.
- When undefined: the stuck counters are absent, code 5 is never produced, and all other behaviour is identical.

Decomposition:
- Package tl_mon_pkg holds:
  - lamp-state enum (UNK/GRN/YEL/RED);
  - top-state enum (RUN/FAULT/ARM);
  - fault code constants FC_NONE..FC_STUCK;
  - lamp pattern constants (LAMP_R = 3'b100, LAMP_Y = 3'b010, LAMP_G = 3'b001).
- Sub-module tl_lamp_tracker holds the per-approach decode, the state FSM, the yellow counter and the stuck counter, and outputs per-approach error flags. It is instantiated twice.
- Conflict detection, priority encoding and the top FSM live in the parent.

Test Plan:
- Legal cycle, A: G,G,G,Y,Y,R; B held R -> no fault. drv_a reproduces the sequence 2 cycles later.
- Conflict: A=001 and B=001 on the same cycle -> 2 cycles later fault=1, fault_code=1, drv_a=drv_b=100. Red then toggles every 4 cycles.
- Bad encoding/transition:
  - A=011 -> code 2.
  - After reset and re-arm, A G->R directly -> code 3.
  - A Y for 1 sample then R -> code 4.
- Priority: in one sample, A=110 (bad encoding) while B changes G->R (bad transition) -> fault_code=2.
- Stuck, with TL_STUCK_WDOG_EN: A and B held R for 200 cycles -> code 5. Without the macro: no fault after 1000 cycles.
- Recovery and reset:
  - ack during FAULT with lamps legal -> one ARM cycle with drv=100, then RUN with fault=0.
  - ack while a conflict is present -> remains in FAULT.
  - pg0 asserted mid-FAULT -> next cycle all outputs at reset values.
